// File: rtl/series_adder_stream_pipe.sv
// Streaming vector summer: accepts an N-word vector, adds L words per clock,
// then holds the RW-bit sum on a valid/ready output until it is taken.
module series_adder_stream_pipe #(
    parameter int N = 8,
    parameter int W = 32,
    parameter int L = 1,
    localparam int RW = W + $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            data_vld,
    input  logic [N*W-1:0]  data_i,
    input  logic            signed_mode,
    output logic            data_rdy,
    output logic [RW-1:0]   result_o,
    output logic            result_vld,
    input  logic            result_rdy,
    output logic            busy
);

    localparam int IW = $clog2(N);

    // Guarded modulus keeps the check itself legal when L is zero.
    generate
        if ((L < 1) || (N < 2) || ((N % ((L < 1) ? 1 : L)) != 0)) begin : g_bad_params
            $error("series_adder_stream_pipe: need N >= 2, L >= 1 and N divisible by L");
        end
    endgenerate

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both 1; valid holds its payload stable until that edge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [N*W-1:0]  data_q;
    logic            sign_q;
    logic [RW-1:0]   acc;
    logic [IW-1:0]   idx;
    logic [RW-1:0]   group_sum;
    logic [W-1:0]    word;
    logic            last_group;

    assign last_group = (idx == IW'(N - L));
    assign data_rdy   = (state == IDLE);
    assign busy       = (state != IDLE);

    always_comb begin
        group_sum = acc;
        word      = '0;
        for (int j = 0; j < L; j++) begin
            word = data_q[(int'(idx) + j) * W +: W];
            if (sign_q)
                group_sum = group_sum + {{(RW-W){word[W-1]}}, word};
            else
                group_sum = group_sum + {{(RW-W){1'b0}}, word};
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (data_vld)   state_nxt = ACC;
            ACC:     if (last_group) state_nxt = OUT;
            OUT:     if (result_rdy) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q     <= '0;
            sign_q     <= 1'b0;
            acc        <= '0;
            idx        <= '0;
            result_o   <= '0;
            result_vld <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (data_vld) begin
                        data_q <= data_i;
                        sign_q <= signed_mode;
                        acc    <= '0;
                        idx    <= '0;
                    end
                end
                ACC: begin
                    // The final group goes straight to the output register.
                    if (last_group) begin
                        result_o   <= group_sum;
                        result_vld <= 1'b1;
                    end else begin
                        acc <= group_sum;
                        idx <= idx + IW'(L);
                    end
                end
                OUT: begin
                    if (result_rdy)
                        result_vld <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_series_adder_stream_pipe.sv
// Bench for series_adder_stream_pipe: an L=1 and an L=4 instance, directed
// vectors, expected sums queued at accept time and checked by monitors.
module tb_series_adder_stream_pipe;

    localparam int N  = 8;
    localparam int W  = 32;
    localparam int RW = 35;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic            rst_n_a, data_vld_a, smode_a, rdy_a, res_vld_a, res_rdy_a, busy_a;
    logic [N*W-1:0]  data_a;
    logic [RW-1:0]   res_a;
    logic            rst_n_b, data_vld_b, smode_b, rdy_b, res_vld_b, res_rdy_b, busy_b;
    logic [N*W-1:0]  data_b;
    logic [RW-1:0]   res_b;

    series_adder_stream_pipe #(.N(8), .W(32), .L(1)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .data_vld(data_vld_a), .data_i(data_a),
        .signed_mode(smode_a), .data_rdy(rdy_a), .result_o(res_a),
        .result_vld(res_vld_a), .result_rdy(res_rdy_a), .busy(busy_a)
    );

    series_adder_stream_pipe #(.N(8), .W(32), .L(4)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .data_vld(data_vld_b), .data_i(data_b),
        .signed_mode(smode_b), .data_rdy(rdy_b), .result_o(res_b),
        .result_vld(res_vld_b), .result_rdy(res_rdy_b), .busy(busy_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [RW-1:0] exp_q_a[$];
    logic [RW-1:0] exp_q_b[$];
    int            lat_q_a[$];
    int            lat_q_b[$];
    int            last_acc_a, last_acc_b;
    logic [31:0]   vec [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_cmp  = n_cmp + 1;
        n_fail = n_fail + 1;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Called and returns at a falling edge; pushes the expected sum on accept.
    task automatic send(input bit sel, input bit smode, input logic [RW-1:0] exp);
        logic [N*W-1:0] d;
        int g;
        g = 0;
        for (int k = 0; k < N; k++) d[k*W +: W] = vec[k];
        while (!(sel ? rdy_b : rdy_a)) begin
            g = g + 1;
            if (g > 60) begin
                flag(sel ? "send_timeout_b" : "send_timeout_a");
                return;
            end
            @(negedge clk);
        end
        if (sel) begin data_vld_b = 1'b1; data_b = d; smode_b = smode; end
        else     begin data_vld_a = 1'b1; data_a = d; smode_a = smode; end
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) d[k*W +: W] = $urandom();
        if (sel) begin
            exp_q_b.push_back(exp); lat_q_b.push_back(cyc); last_acc_b = cyc;
            data_vld_b = 1'b0; data_b = d; smode_b = ~smode;
        end else begin
            exp_q_a.push_back(exp); lat_q_a.push_back(cyc); last_acc_a = cyc;
            data_vld_a = 1'b0; data_a = d; smode_a = ~smode;
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input bit sel);
        int g;
        g = 0;
        while ((sel ? busy_b : busy_a) || (sel ? exp_q_b.size() : exp_q_a.size()) != 0) begin
            g = g + 1;
            if (g > 100) begin
                flag(sel ? "idle_timeout_b" : "idle_timeout_a");
                return;
            end
            @(negedge clk);
        end
    endtask

    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    int   t_a, t_b;

    always begin
        @(negedge clk);
        #1;
        if (!rst_n_a) prev_a = 1'b0;
        else begin
            if (res_vld_a && !prev_a) begin
                if (lat_q_a.size() == 0) flag("unexpected_result_a");
                else begin
                    t_a = lat_q_a.pop_front();
                    check("latency_a", 64'(cyc - t_a), 64'd8);
                end
            end
            if (res_vld_a && res_rdy_a) begin
                if (exp_q_a.size() == 0) flag("unexpected_handshake_a");
                else check("sum_a", 64'(res_a), 64'(exp_q_a.pop_front()));
            end
            prev_a = res_vld_a;
        end
    end

    always begin
        @(negedge clk);
        #1;
        if (!rst_n_b) prev_b = 1'b0;
        else begin
            if (res_vld_b && !prev_b) begin
                if (lat_q_b.size() == 0) flag("unexpected_result_b");
                else begin
                    t_b = lat_q_b.pop_front();
                    check("latency_b", 64'(cyc - t_b), 64'd2);
                end
            end
            if (res_vld_b && res_rdy_b) begin
                if (exp_q_b.size() == 0) flag("unexpected_handshake_b");
                else check("sum_b", 64'(res_b), 64'(exp_q_b.pop_front()));
            end
            prev_b = res_vld_b;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic seen;
        rst_n_a = 1'b0; data_vld_a = 1'b0; data_a = '0; smode_a = 1'b0; res_rdy_a = 1'b1;
        rst_n_b = 1'b0; data_vld_b = 1'b0; data_b = '0; smode_b = 1'b0; res_rdy_b = 1'b1;
        repeat (3) @(negedge clk);

        check("reset_rdy_a",  64'(rdy_a), 64'd1);
        check("reset_vld_a",  64'(res_vld_a), 64'd0);
        check("reset_res_a",  64'(res_a), 64'd0);
        check("reset_busy_a", 64'(busy_a), 64'd0);
        check("reset_rdy_b",  64'(rdy_b), 64'd1);
        check("reset_vld_b",  64'(res_vld_b), 64'd0);
        check("reset_res_b",  64'(res_b), 64'd0);
        check("reset_busy_b", 64'(busy_b), 64'd0);

        // First edge after release must accept.
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        vec = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        send(1'b0, 1'b0, 35'd36);
        check("first_accept_cycle", 64'(last_acc_a), 64'd4);
        check("acc_busy_a", 64'(busy_a), 64'd1);
        check("acc_rdy_a",  64'(rdy_a), 64'd0);
        wait_idle(1'b0);

        vec = '{default: 32'hFFFF_FFFF};
        send(1'b0, 1'b0, 35'h7_FFFF_FFF8);
        wait_idle(1'b0);

        vec = '{32'd5, 32'hFFFF_FFFD, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        send(1'b0, 1'b1, 35'd2);
        wait_idle(1'b0);
        send(1'b0, 1'b0, 35'h1_0000_0002);
        wait_idle(1'b0);

        vec = '{32'h8000_0000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        send(1'b0, 1'b1, 35'h7_8000_0000);
        wait_idle(1'b0);
        send(1'b0, 1'b0, 35'h0_8000_0000);
        t0 = last_acc_a;
        vec = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        send(1'b0, 1'b0, 35'd36);
        check("accept_interval_a", 64'(last_acc_a - t0), 64'd10);
        wait_idle(1'b0);

        // Backpressure with ignored data_vld pulses while the result is held.
        res_rdy_a = 1'b0;
        vec = '{32'd100, 32'd200, 32'd300, 32'd400, 32'd500, 32'd600, 32'd700, 32'd800};
        send(1'b0, 1'b0, 35'd3600);
        t0 = 0;
        while (!res_vld_a && t0 < 30) begin t0 = t0 + 1; @(negedge clk); end
        for (int i = 0; i < 5; i++) begin
            data_vld_a = ~i[0];
            data_a     = {8{$urandom()}};
            check("bp_res_a", 64'(res_a), 64'd3600);
            check("bp_vld_a", 64'(res_vld_a), 64'd1);
            check("bp_rdy_a", 64'(rdy_a), 64'd0);
            @(negedge clk);
        end
        data_vld_a = 1'b0;
        res_rdy_a  = 1'b1;
        @(negedge clk);
        check("post_hs_vld_a",  64'(res_vld_a), 64'd0);
        check("post_hs_rdy_a",  64'(rdy_a), 64'd1);
        check("post_hs_hold_a", 64'(res_a), 64'd3600);
        wait_idle(1'b0);

        // Reset on the third ACC edge discards the vector.
        vec = '{32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9};
        send(1'b0, 1'b0, 35'd72);
        @(negedge clk);
        rst_n_a = 1'b0;
        @(negedge clk);
        exp_q_a.delete();
        lat_q_a.delete();
        check("midreset_rdy_a",  64'(rdy_a), 64'd1);
        check("midreset_vld_a",  64'(res_vld_a), 64'd0);
        check("midreset_res_a",  64'(res_a), 64'd0);
        check("midreset_busy_a", 64'(busy_a), 64'd0);
        rst_n_a = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seen = seen | res_vld_a;
            @(negedge clk);
        end
        check("midreset_no_vld_a", 64'(seen), 64'd0);
        vec = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        send(1'b0, 1'b0, 35'd36);
        wait_idle(1'b0);

        // Four lanes per clock.
        vec = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd80};
        send(1'b1, 1'b0, 35'd360);
        wait_idle(1'b1);
        vec = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'd5, 32'd0, 32'd0, 32'd0};
        send(1'b1, 1'b1, 35'd1);
        wait_idle(1'b1);
        send(1'b1, 1'b0, 35'h4_0000_0001);
        wait_idle(1'b1);

        repeat (3) @(negedge clk);
        check("exp_q_a_drained", 64'(exp_q_a.size()), 64'd0);
        check("exp_q_b_drained", 64'(exp_q_b.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/series_adder_stream_pipe.md
SERIES_ADDER_STREAM_PIPE -- requirements
Module: series_adder_stream_pipe

Interface
REQ-001 SHALL provide the following parameters:
- N, 8, number of words per input vector.
- W, 32, word width in bits.
- L, 1, words summed per clock (lanes).
- RW, W+$clog2(N), result width (derived, not overridden).
REQ-002 SHALL provide the following ports (clock and reset first):
- clk  in  1  sole clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- data_vld  in  1  input vector valid.
- data_i  in  N*W  packed vector; word k at bits [k*W+W-1 : k*W].
- signed_mode  in  1  1 = two's-complement words, 0 = unsigned; sampled with data_i.
- data_rdy  out  1  block can accept a vector.
- result_o  out  RW  sum of the accepted vector.
- result_vld  out  1  result_o valid.
- result_rdy  in  1  downstream accepts the result.
- busy  out  1  high in ACC or OUT.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 SHALL fail elaboration if N mod L != 0, L < 1 or N < 2.

Function
REQ-005 SHALL implement FSM states IDLE, ACC and OUT.
REQ-006 In IDLE, data_rdy SHALL be 1; in ACC and OUT it SHALL be 0.
REQ-007 Accept event = data_vld & data_rdy at a rising edge. On accept: register data_i and signed_mode, clear the accumulator to 0, set word index to 0, go to ACC.
REQ-008 In ACC, each cycle SHALL add words [idx .. idx+L-1] to the accumulator and advance idx by L. Each word is sign-extended to RW when the registered signed_mode = 1, zero-extended otherwise.
REQ-009 The cycle that adds the final group (idx = N-L) SHALL load result_o with the complete sum, set result_vld = 1 and go to OUT. result_vld therefore rises exactly N/L edges after the accept edge.
REQ-010 The arithmetic SHALL be modulo 2^RW and cannot overflow within range. result_o is two's-complement when signed, unsigned otherwise.
REQ-011 In OUT, result_o and result_vld SHALL stay stable until result_rdy = 1 at an edge. That edge clears result_vld and returns to IDLE.
REQ-012 result_o SHALL keep its last value after the handshake until the next result is loaded.
REQ-013 data_vld while data_rdy = 0 SHALL be ignored, with no capture and no state change. Changes on data_i or signed_mode after the accept edge SHALL NOT affect the in-flight sum.
REQ-014 result_rdy outside OUT SHALL have no effect.
REQ-015 When result_rdy is held high, the accept-to-accept interval SHALL be N/L+2 cycles. The next data_rdy rises one edge after the result handshake.
REQ-016 busy SHALL equal (state != IDLE).

Reset
REQ-017 While rst_n = 0 at an edge, the block SHALL set: state = IDLE, data_rdy = 1 (effective after that edge), result_vld = 0, result_o = 0, busy = 0, accumulator = 0, idx = 0.
REQ-018 Reset asserted mid-ACC or mid-OUT SHALL discard the in-flight vector and result without emitting a result_vld pulse.
REQ-019 The first accept after reset release SHALL be possible on the first edge with rst_n = 1.

Verification
REQ-020 N=8, W=32, L=1, unsigned, words 1..8 -> result_o = 36 (RW = 35), result_vld rises 8 edges after accept.
REQ-021 Unsigned, all words 0xFFFFFFFF -> result_o = 0x7FFFFFFF8.
REQ-022 Word0 = 5, word1 = 0xFFFFFFFD, rest 0 -> signed_mode=1 gives result_o = 2; signed_mode=0 gives 0x100000002.
REQ-023 Backpressure: result_rdy held 0 for 5 cycles in OUT while data_vld pulses -> result_o and result_vld stable, data_rdy = 0, no capture. result_rdy = 1 -> IDLE next edge.
REQ-024 L=4, N=8, words 10,20,...,80 -> result_o = 360, result_vld rises 2 edges after accept.
REQ-025 rst_n = 0 for one edge at ACC cycle 3 -> all outputs at reset values, no result_vld. The next vector of words 1..8 yields 36.
